// File: rtl/simple_rf_arb_pkg.sv
// Shared types and helpers for the register-file arbiter: FSM state,
// requester count and the 2-way round-robin pick.
package simple_rf_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned NREQ = 2;

  // One candidate wins outright; on contention ptr names the winner.
  function automatic logic [1:0] rr_pick2(input logic [1:0] valid, input logic ptr);
    logic [1:0] grant;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
    return grant;
  endfunction

endpackage

// File: rtl/simple_rf_arb_rr_arb2.sv
// Two-way round-robin arbiter. The priority pointer flips only when both
// requesters compete, so an uncontested requester never disturbs fairness.
module rr_arb2
  import simple_rf_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = rr_pick2(valid, ptr_q);
    ptr_d = ptr_q;
    // The winner is ptr_q, so the loser gets priority next time.
    if (&valid) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/simple_rf_arb.sv
// Shares a 1W/1R register file between two requesters: clears the RF after
// reset, then arbitrates the write and read ports independently.
module simple_rf_arb
  import simple_rf_pkg::*;
#(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 init_done,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic [AW-1:0]        rf_raddr,
  input  logic [DW-1:0]        rf_rdata
);

  localparam logic [AW-1:0] ClrLast = {AW{1'b1}};

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic              init_done_q, init_done_d;

  logic              run;
  logic [NREQ-1:0]   wr_cand, rd_cand;
  logic [NREQ-1:0]   wr_grant, rd_grant;

  assign run = (state_q == RUN);

  // Gating candidates with run keeps both arbiter pointers frozen during the sweep.
  assign wr_cand = req_valid & req_we & {NREQ{run}};
  assign rd_cand = req_valid & ~req_we & {NREQ{run}};

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .valid (wr_cand),
    .grant (wr_grant)
  );

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .valid (rd_cand),
    .grant (rd_grant)
  );

  assign req_ready = wr_grant | rd_grant;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      INIT: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == ClrLast) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_raddr = '0;
    if (!run) begin
      rf_we    = 1'b1;
      rf_waddr = clr_cnt_q;
    end else begin
      rf_we = |wr_grant;
      for (int i = 0; i < NREQ; i++) begin
        if (wr_grant[i]) begin
          rf_waddr = req_addr[i*AW +: AW];
          rf_wdata = req_wdata[i*DW +: DW];
        end
        if (rd_grant[i]) begin
          rf_raddr = req_addr[i*AW +: AW];
        end
      end
    end
  end

  // RF read is combinational, so the grant-cycle rf_rdata is the pre-write value.
  always_comb begin
    rsp_valid_d = rd_grant;
    rsp_data_d  = rsp_data_q;
    if (|rd_grant) begin
      rsp_data_d = rf_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      clr_cnt_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_simple_rf_arb.sv
// Directed bench for simple_rf_arb with an RF model and a response scoreboard.
module tb_simple_rf_arb;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 2;
  localparam int unsigned Depth = 1 << AW;

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [2*AW-1:0]   req_addr;
  logic [2*DW-1:0]   req_wdata;
  logic [1:0]        rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              init_done;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [AW-1:0]     rf_raddr;
  logic [DW-1:0]     rf_rdata;

  simple_rf_arb #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .init_done (init_done),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata)
  );

  // Register file instance: combinational read, posedge write.
  logic [DW-1:0] rf_mem [Depth];
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata = rf_mem[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    vld;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb_q[$];
  logic [DW-1:0] ref_mem [Depth];
  logic [DW-1:0] last_data;
  int            n_total;
  int            n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Eight clear cycles; reset is released on the first negedge.
  task automatic sweep(input string tag);
    for (int i = 0; i < int'(Depth); i++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk({tag, ":init_we"}, 32'(rf_we), 32'd1);
      chk({tag, ":init_waddr"}, 32'(rf_waddr), 32'(i));
      chk({tag, ":init_wdata"}, 32'(rf_wdata), 32'd0);
      chk({tag, ":init_raddr"}, 32'(rf_raddr), 32'd0);
      chk({tag, ":init_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ":init_done_lo"}, 32'(init_done), 32'd0);
      chk({tag, ":init_rsp_valid"}, 32'(rsp_valid), 32'd0);
    end
    for (int i = 0; i < int'(Depth); i++) ref_mem[i] = '0;
    last_data = '0;
  endtask

  // One RUN cycle: drive, check combinational port muxing, score the response.
  task automatic cyc(input logic [1:0] v, input logic [1:0] we,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input logic [1:0] exp_rdy, input string tag);
    logic [1:0]    wg, rg;
    logic [AW-1:0] exp_raddr;
    rsp_t          e;
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    wg = exp_rdy & v & we;
    rg = exp_rdy & v & ~we;
    chk({tag, ":ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({tag, ":init_done"}, 32'(init_done), 32'd1);
    chk({tag, ":rf_we"}, 32'(rf_we), 32'(|wg));
    if (wg[0]) begin
      chk({tag, ":waddr"}, 32'(rf_waddr), 32'(a0));
      chk({tag, ":wdata"}, 32'(rf_wdata), 32'(d0));
    end else if (wg[1]) begin
      chk({tag, ":waddr"}, 32'(rf_waddr), 32'(a1));
      chk({tag, ":wdata"}, 32'(rf_wdata), 32'(d1));
    end
    exp_raddr = rg[1] ? a1 : (rg[0] ? a0 : '0);
    chk({tag, ":raddr"}, 32'(rf_raddr), 32'(exp_raddr));
    if (rg != 2'b00) begin
      e.vld     = rg;
      e.data    = ref_mem[exp_raddr];
      last_data = e.data;
    end else begin
      e.vld  = 2'b00;
      e.data = last_data;
    end
    sb_q.push_back(e);
    // Write lands after the read was sampled: no bypass.
    if (wg[0]) ref_mem[a0] = d0;
    else if (wg[1]) ref_mem[a1] = d1;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(e.vld));
    chk({tag, ":rsp_data"}, 32'(rsp_data), 32'(e.data));
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    last_data = '0;
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:rsp_data", 32'(rsp_data), 32'd0);
    chk("rst:init_done", 32'(init_done), 32'd0);
    chk("rst:ready", 32'(req_ready), 32'd0);

    // 1: clear sweep while idle
    sweep("t1");

    // 2: write then read-back on the other requester
    cyc(2'b01, 2'b01, 3'd5, 3'd0, 2'b11, 2'b00, 2'b01, "t2_wr");
    cyc(2'b10, 2'b00, 3'd0, 3'd5, 2'b00, 2'b00, 2'b10, "t2_rd");

    // 3: contested writes alternate
    for (int k = 0; k < 4; k++) begin
      cyc(2'b11, 2'b11, 3'd1, 3'd2, 2'd1, 2'd2, (k % 2 == 0) ? 2'b01 : 2'b10, "t3_wr");
    end
    cyc(2'b01, 2'b00, 3'd1, 3'd0, 2'd0, 2'd0, 2'b01, "t3_rd1");
    cyc(2'b10, 2'b00, 3'd0, 3'd2, 2'd0, 2'd0, 2'b10, "t3_rd2");

    // 4: same-cycle write and read of addr 3 returns the old value
    cyc(2'b11, 2'b01, 3'd3, 3'd3, 2'b10, 2'b00, 2'b11, "t4_rw");
    cyc(2'b10, 2'b00, 3'd0, 3'd3, 2'b00, 2'b00, 2'b10, "t4_rd");

    // 5: reset lands on a granted read
    @(negedge clk);
    req_valid = 2'b10;
    req_we    = 2'b00;
    req_addr  = {3'd2, 3'd0};
    reset     = 1'b1;
    #1;
    chk("t5:ready_pre_reset", 32'(req_ready), 32'b10);
    @(posedge clk);
    #1;
    chk("t5:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5:init_done", 32'(init_done), 32'd0);
    sweep("t5");
    cyc(2'b10, 2'b00, 3'd0, 3'd2, 2'd0, 2'd0, 2'b10, "t5_rd2");
    cyc(2'b01, 2'b00, 3'd3, 3'd0, 2'd0, 2'd0, 2'b01, "t5_rd3");

    // 6: contested reads round-robin; lone writer always wins its port
    cyc(2'b11, 2'b00, 3'd6, 3'd7, 2'd0, 2'd0, 2'b01, "t6_rr0");
    cyc(2'b11, 2'b00, 3'd6, 3'd7, 2'd0, 2'd0, 2'b10, "t6_rr1");
    cyc(2'b11, 2'b10, 3'd6, 3'd7, 2'd0, 2'b01, 2'b11, "t6_wr");
    cyc(2'b11, 2'b00, 3'd6, 3'd7, 2'd0, 2'd0, 2'b01, "t6_rr2");
    cyc(2'b11, 2'b00, 3'd6, 3'd7, 2'd0, 2'd0, 2'b10, "t6_rr3");
    cyc(2'b11, 2'b10, 3'd6, 3'd7, 2'd0, 2'b11, 2'b11, "t6_wr2");
    cyc(2'b10, 2'b00, 3'd0, 3'd7, 2'd0, 2'd0, 2'b10, "t6_rd7");

    @(negedge clk);
    req_valid = '0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
